dot_product_driver: RTL and testbench
=====================================

Name: dot_product_driver

Overview:
- Feeds the time-multiplexed dot-product engine from a serial stream of (weight, pixel) pairs.
- Assembles N-element vectors into a double buffer and presents each complete vector to the engine as stable parallel buses.
- Frames each engine run with the engine's active-high reset, captures the engine result at a fixed frame cycle, and returns it over a valid/ready handshake.
- Sits between the weight/pixel memory sequencer and the engine.

Parameters:
- N, 10, elements per vector.
- A_W, 19, weight width.
- B_W, 10, pixel width.
- R_W, 26, result width.
- RESULT_LAT, 29, frame cycle at which engine output holds the final sum. Legal range 1..FRAME_LEN-1.
- FRAME_LEN, 30, engine frame length in cycles. Used only for the legality check.

Ports:
- clk  in  1  clock.
- GlobalReset  in  1  synchronous reset, active-low.
- in_valid  in  1  input pair valid.
- in_ready  out  1  driver can accept a pair.
- in_a  in  A_W  weight.
- in_b  in  B_W  pixel.
- dp_rst  out  1  active-high reset to engine; engine runs while low.
- dp_a  out  N*A_W  weights; element i at [i*A_W +: A_W].
- dp_b  out  N*B_W  pixels; element i at [i*B_W +: B_W].
- dp_value  in  R_W  engine result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  R_W  captured result.

Behaviour:
- Reset: clk only; GlobalReset is active-low and synchronous. GlobalReset=0 at a rising edge sets:
  - load_cnt=0, frame_cnt=0, state=IDLE
  - dp_rst=1, dp_a=0, dp_b=0
  - out_valid=0, out_data=0
  - Load buffer contents are don't-care.
  - Applies mid-run too: the run and any partially loaded vector are discarded.
- Load side:
  - in_ready = (load_cnt < N), combinational from registers.
  - On in_valid && in_ready: load slot load_cnt gets {in_a, in_b}; load_cnt++.
  - Slot order equals arrival order. Gaps in in_valid are allowed.
  - Loading proceeds independently of compute state (double buffer).
- Compute FSM, states IDLE, RUN, HOLD:
  - IDLE: dp_rst=1. If load_cnt==N, then on the next edge:
    - copy load buffer to dp_a/dp_b;
    - load_cnt=0, frame_cnt=0, dp_rst=0, state=RUN.
  - RUN:
    - dp_a/dp_b frozen.
    - The first cycle with dp_rst=0 is frame cycle 0; frame_cnt increments each cycle.
    - At the edge ending frame cycle RESULT_LAT: out_data<=dp_value, out_valid<=1, dp_rst<=1, state=HOLD.
  - HOLD:
    - dp_rst=1; out_valid and out_data stable until handshake.
    - On out_valid && out_ready: out_valid<=0.
    - If load_cnt==N in that same cycle, start a new run at that edge (copy, dp_rst<=0, RUN). Otherwise go to IDLE.
- Guarantees:
  - dp_rst high for at least one cycle between runs (the first HOLD cycle).
  - Minimum spacing between run starts: RESULT_LAT+2 cycles.
- Simultaneous events:
  - The 10th accepted pair and the swap never coincide: the swap requires load_cnt==N, which forces in_ready=0 that cycle.
  - The load_cnt clear on swap takes priority over any increment (none is possible that cycle).
- No arithmetic in the driver; widths are pass-through. dp_value is sampled unmodified.
- Latency: last pair accepted at edge E; with compute IDLE, dp_rst falls at E+1 and out_valid rises at E+1+RESULT_LAT+1.

Test Plan:
1. Reset: GlobalReset=0 for 3 cycles with in_valid=1 -> dp_rst=1, in_ready=1, out_valid=0, out_data=0, dp_a=0, dp_b=0, and no pair accepted.
2. Single vector: 10 back-to-back pairs a_i=i+1, b_i=2; engine stub drives 26'h0ABCDE only at frame cycle 29 -> in_ready=0 after the 10th pair; dp_rst falls 1 cycle later; dp_a slot 0=1 through slot 9=10; out_valid rises 30 cycles after dp_rst falls with out_data=26'h0ABCDE; dp_rst=1 thereafter.
3. Double buffer: 20 continuous pairs, out_ready=1 -> second vector fully accepted during run 1; run 2 starts on the handshake edge; dp_rst high exactly 1 cycle between runs; two results in order.
4. Backpressure: out_ready=0 for 50 cycles after first result, second vector loaded -> out_valid and out_data stable, dp_rst=1, in_ready=0; on out_ready=1, handshake occurs and run 2 starts the same edge.
5. Mid-run reset: GlobalReset=0 at frame cycle 12 with 4 pairs in the load buffer -> next cycle all reset values hold; 10 fresh pairs then produce a correct run containing no stale data.
6. Sparse input: in_valid toggles every other cycle with distinct values -> exactly 10 accepted, slot i equals the i-th accepted pair, run starts 1 cycle after the 10th.

Source files
------------

// File: rtl/dot_product_driver.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_driver
// Purpose  : Double-buffers serial (weight, pixel) pairs into N-element vectors,
//            frames each engine run with dp_rst and returns the captured sum.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_driver #(
    parameter int N          = 10,
    parameter int A_W        = 19,
    parameter int B_W        = 10,
    parameter int R_W        = 26,
    parameter int RESULT_LAT = 29,
    parameter int FRAME_LEN  = 30
) (
    input  logic               clk,
    input  logic               GlobalReset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    output logic               dp_rst,
    output logic [N*A_W-1:0]   dp_a,
    output logic [N*B_W-1:0]   dp_b,
    input  logic [R_W-1:0]     dp_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [R_W-1:0]     out_data
);

    localparam int LC_W = $clog2(N + 1);
    localparam int FC_W = (RESULT_LAT < 1) ? 1 : $clog2(RESULT_LAT + 1);
    localparam logic [LC_W-1:0] c_N          = LC_W'(N);
    localparam logic [FC_W-1:0] c_RESULT_LAT = FC_W'(RESULT_LAT);

    if (RESULT_LAT < 1 || RESULT_LAT >= FRAME_LEN) begin : g_bad_result_lat
        $error("RESULT_LAT must lie in 1..FRAME_LEN-1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LC_W-1:0]     r_load_cnt;
    logic [FC_W-1:0]     r_frame_cnt;
    logic [A_W-1:0]      r_load_a [N];
    logic [B_W-1:0]      r_load_b [N];
    logic [N*A_W-1:0]    w_load_a_flat;
    logic [N*B_W-1:0]    w_load_b_flat;
    logic                w_full;
    logic                w_load;
    logic                w_swap;
    logic                w_capture;
    logic                w_handshake;

    assign w_full      = (r_load_cnt == c_N);
    assign in_ready    = (r_load_cnt < c_N);
    assign w_load      = in_valid && in_ready;
    assign w_handshake = out_valid && out_ready;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign w_load_a_flat[i*A_W +: A_W] = r_load_a[i];
        assign w_load_b_flat[i*B_W +: B_W] = r_load_b[i];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_full) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_frame_cnt == c_RESULT_LAT) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Back-to-back run: the handshake edge doubles as the next start.
                if (w_handshake) begin
                    if (w_full) begin
                        w_swap      = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load buffer holds no meaningful state across reset; the count gates it.
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int i = 0; i < N; i++) begin
                if (r_load_cnt == LC_W'(i)) begin
                    r_load_a[i] <= in_a;
                    r_load_b[i] <= in_b;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            r_load_cnt  <= '0;
            r_frame_cnt <= '0;
            dp_rst      <= 1'b1;
            dp_a        <= '0;
            dp_b        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (w_swap) begin
                r_load_cnt <= '0;
            end else if (w_load) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end

            if (w_swap) begin
                dp_a        <= w_load_a_flat;
                dp_b        <= w_load_b_flat;
                dp_rst      <= 1'b0;
                r_frame_cnt <= '0;
            end else if (w_capture) begin
                out_data  <= dp_value;
                out_valid <= 1'b1;
                dp_rst    <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            if (w_handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_driver
// Purpose  : Directed self-checking bench for dot_product_driver with an engine stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_driver;

    localparam int N          = 10;
    localparam int A_W        = 19;
    localparam int B_W        = 10;
    localparam int R_W        = 26;
    localparam int RESULT_LAT = 29;
    localparam int FRAME_LEN  = 30;

    logic               clk = 1'b0;
    logic               GlobalReset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [A_W-1:0]     in_a = '0;
    logic [B_W-1:0]     in_b = '0;
    logic               dp_rst;
    logic [N*A_W-1:0]   dp_a;
    logic [N*B_W-1:0]   dp_b;
    logic [R_W-1:0]     dp_value;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [R_W-1:0]     out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dot_product_driver #(
        .N(N), .A_W(A_W), .B_W(B_W), .R_W(R_W),
        .RESULT_LAT(RESULT_LAT), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .GlobalReset(GlobalReset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dp_rst(dp_rst), .dp_a(dp_a), .dp_b(dp_b), .dp_value(dp_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    function automatic logic [R_W-1:0] dot(input logic [N*A_W-1:0] a, input logic [N*B_W-1:0] b);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + 64'(a[i*A_W +: A_W]) * 64'(b[i*B_W +: B_W]);
        return s[R_W-1:0];
    endfunction

    // Engine stub: the final sum is only visible during frame cycle RESULT_LAT.
    int fc = 0;
    bit use_dot = 1'b0;
    always @(posedge clk) begin
        if (dp_rst !== 1'b0) fc <= 0;
        else                 fc <= fc + 1;
    end
    always_comb begin
        dp_value = 26'h1555555;
        if (dp_rst === 1'b0 && fc == RESULT_LAT)
            dp_value = use_dot ? dot(dp_a, dp_b) : 26'h0ABCDE;
    end

    logic [R_W-1:0] res_q [$];
    int             gap_q [$];
    int             hi_cnt = 0;
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) res_q.push_back(out_data);
        if (dp_rst === 1'b1) hi_cnt++;
        else if (dp_rst === 1'b0 && hi_cnt > 0) begin
            gap_q.push_back(hi_cnt);
            hi_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        int   t;
        logic acc;
        t = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        do begin
            acc = in_ready;
            tick();
            t++;
        end while (acc !== 1'b1 && t < 200);
        if (acc !== 1'b1) check("send_timeout", 0, 1);
    endtask

    task automatic wait_ov(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, (n < 200), 1);
    endtask

    logic [N*A_W-1:0] exp_a;
    logic [N*B_W-1:0] exp_b;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, t;

        // 1: reset with in_valid asserted
        GlobalReset = 1'b0; in_valid = 1'b1; in_a = 19'd5; in_b = 10'd5;
        repeat (3) tick();
        check("rst_dp_rst", dp_rst, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_dp_a", dp_a, 0);
        check("rst_dp_b", dp_b, 0);
        in_valid = 1'b0;
        GlobalReset = 1'b1;
        tick();

        // 2: single vector, fixed stub result
        use_dot = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            send_pair(A_W'(i + 1), 10'd2);
            check("t2_in_ready", in_ready, (i < N - 1));
            exp_a[i*A_W +: A_W] = A_W'(i + 1);
            exp_b[i*B_W +: B_W] = 10'd2;
        end
        in_valid = 1'b0;
        check("t2_rst_before", dp_rst, 1);
        tick();
        check("t2_rst_fall", dp_rst, 0);
        check("t2_dp_a", dp_a, exp_a);
        check("t2_dp_b", dp_b, exp_b);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
        check("t2_latency", n, RESULT_LAT + 1);
        check("t2_out_data", out_data, 26'h0ABCDE);
        check("t2_rst_hold", dp_rst, 1);
        out_ready = 1'b1;
        tick();
        check("t2_ov_drop", out_valid, 0);
        tick();
        check("t2_rst_idle", dp_rst, 1);

        // 3: double buffer, 20 continuous pairs
        use_dot = 1'b1;
        res_q.delete(); gap_q.delete();
        for (int i = 0; i < 2 * N; i++) send_pair(A_W'(i + 1), (i < N) ? 10'd2 : 10'd3);
        in_valid = 1'b0;
        check("t3_loaded_in_run1", dp_rst, 0);
        t = 0;
        while (res_q.size() < 2 && t < 300) begin tick(); t++; end
        check("t3_n_results", res_q.size(), 2);
        check("t3_res0", (res_q.size() > 0) ? res_q[0] : '1, 26'd110);
        check("t3_res1", (res_q.size() > 1) ? res_q[1] : '1, 26'd465);
        check("t3_gap", (gap_q.size() > 1) ? gap_q[gap_q.size() - 1] : 0, 1);
        tick();

        // 4: backpressure with second vector waiting
        out_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (i < N) send_pair(A_W'(21 + i), 10'd1);
            else       send_pair(A_W'(100 + i - N), B_W'(i - N));
        end
        in_valid = 1'b0;
        wait_ov("t4_ov_timeout");
        check("t4_res0", out_data, 26'd255);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 26'd255 || dp_rst !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("t4_stable_cycles_bad", bad, 0);
        check("t4_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("t4_hs_ov", out_valid, 0);
        check("t4_hs_run", dp_rst, 0);
        check("t4_hs_in_ready", in_ready, 1);
        wait_ov("t4_ov2_timeout");
        check("t4_res1", out_data, 26'd4785);
        tick();
        check("t4_ov2_drop", out_valid, 0);

        // 5: reset during frame cycle 12 with 4 pairs buffered
        res_q.delete();
        for (int i = 0; i < N; i++) send_pair(A_W'(i + 3), 10'd5);
        in_valid = 1'b0;
        tick();
        check("t5_run", dp_rst, 0);
        for (int i = 0; i < 4; i++) send_pair(A_W'(500 + i), 10'd77);
        in_valid = 1'b0;
        repeat (8) tick();
        GlobalReset = 1'b0;
        tick();
        GlobalReset = 1'b1;
        check("t5_dp_rst", dp_rst, 1);
        check("t5_in_ready", in_ready, 1);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_data", out_data, 0);
        check("t5_dp_a", dp_a, 0);
        check("t5_dp_b", dp_b, 0);
        for (int i = 0; i < N; i++) begin
            send_pair(A_W'(2 * i + 1), B_W'(i + 1));
            exp_a[i*A_W +: A_W] = A_W'(2 * i + 1);
            exp_b[i*B_W +: B_W] = B_W'(i + 1);
        end
        in_valid = 1'b0;
        check("t5_full", in_ready, 0);
        tick();
        check("t5_dp_a_fresh", dp_a, exp_a);
        check("t5_dp_b_fresh", dp_b, exp_b);
        wait_ov("t5_ov_timeout");
        check("t5_res", out_data, 26'd715);
        tick();
        check("t5_one_result", res_q.size(), 1);

        // 6: sparse input with junk on idle cycles
        for (int i = 0; i < N; i++) begin
            exp_a[i*A_W +: A_W] = A_W'(1000 + 37 * i);
            exp_b[i*B_W +: B_W] = B_W'(1000 - 50 * i);
            in_valid = 1'b1;
            in_a = exp_a[i*A_W +: A_W];
            in_b = exp_b[i*B_W +: B_W];
            tick();
            in_valid = 1'b0;
            in_a = '1;
            in_b = '1;
            if (i < N - 1) tick();
        end
        check("t6_full", in_ready, 0);
        check("t6_rst_before", dp_rst, 1);
        tick();
        check("t6_rst_fall", dp_rst, 0);
        check("t6_dp_a", dp_a, exp_a);
        check("t6_dp_b", dp_b, exp_b);
        wait_ov("t6_ov_timeout");
        check("t6_res", out_data, dot(exp_a, exp_b));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
